// File: rtl/spi_adc_pkg.sv
// Shared types and constants for the LTC2308-style SPI ADC responder.
// The config word layout is {S/D, O/S, S1, S0, UNI, SLP}, MSB first.
package spi_adc_pkg;

    localparam int CFG_W    = 6;
    localparam int SAMPLE_W = 12;
    localparam int NUM_CH   = 8;
    localparam int CH_IDX_W = 3;
    localparam int TX_W     = SAMPLE_W + 4;

    localparam int CFG_SD  = 5;
    localparam int CFG_OS  = 4;
    localparam int CFG_S1  = 3;
    localparam int CFG_S0  = 2;
    localparam int CFG_UNI = 1;
    localparam int CFG_SLP = 0;

    // Channel 0, single-ended, unipolar off, no sleep
    localparam logic [CFG_W-1:0] CFG_RESET = 6'b100000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

    function automatic logic [SAMPLE_W-1:0] select_sample(
        input logic [NUM_CH*SAMPLE_W-1:0] samples,
        input logic                       single_ended,
        input logic [CH_IDX_W-1:0]        idx
    );
        logic [SAMPLE_W-1:0] result;
        result = '0;
        if (single_ended) begin
            result = samples[idx*SAMPLE_W +: SAMPLE_W];
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev_reg;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic stage_reg;
        logic stage_in;

        if (gi == 0) begin : g_first
            assign stage_in = din;
        end else begin : g_chain
            assign stage_in = g_stage[gi-1].stage_reg;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stage_reg <= RESET_VAL;
            end else begin
                stage_reg <= stage_in;
            end
        end
    end

    assign level = g_stage[STAGES-1].stage_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_reg <= RESET_VAL;
        end else begin
            prev_reg <= level;
        end
    end

    assign rise = level & ~prev_reg;
    assign fall = ~level & prev_reg;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI slave that mimics an LTC2308: returns the sample picked by the previous
// frame's config word while capturing the next config from MOSI.
module spi_adc_responder
    import spi_adc_pkg::*;
#(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    input  logic                         spi_SCLK,
    input  logic                         spi_SS_n,
    input  logic                         spi_MOSI,
    output logic                         spi_MISO,
    input  logic [NUM_CH*SAMPLE_W-1:0]   ch_data,
    output logic [CFG_W-1:0]             cfg_word,
    output logic                         cfg_valid,
    output logic                         frame_err
);

    localparam int CNT_W   = $clog2(FRAME_BITS + 1);
    localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(SYNC_STAGES + 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic ss_level, ss_rise, ss_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_edges;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .din   (spi_SCLK),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .din   (spi_SS_n),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (clk_clk),
        .rst   (reset_reset),
        .din   (spi_MOSI),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign unused_edges = ^{sclk_level, mosi_rise, mosi_fall};

    spi_state_e            state_reg, state_next;
    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [TX_W-1:0]       tx_shift_reg, tx_shift_next;
    logic [TX_W-1:0]       rx_shift_reg, rx_shift_next;
    logic [TX_W-1:0]       rx_shifted;
    logic [CFG_W-1:0]      cfg_word_reg, cfg_word_next;
    logic                  cfg_valid_reg, cfg_valid_next;
    logic                  frame_err_reg, frame_err_next;
    logic                  miso_reg, miso_next;
    logic                  armed_reg, armed_next;
    logic [PRIME_W-1:0]    prime_cnt_reg, prime_cnt_next;
    logic                  sync_primed;
    logic [CH_IDX_W-1:0]   ch_idx;
    logic [SAMPLE_W-1:0]   sel_sample;

    // The SS_n synchronizer resets high, so its level is only trusted once
    // real pin values have flushed through; otherwise a held-low SS_n across
    // reset would look like "seen high" and arm a bogus frame.
    assign sync_primed    = (prime_cnt_reg == PRIME_DONE);
    assign prime_cnt_next = sync_primed ? prime_cnt_reg : prime_cnt_reg + PRIME_W'(1);
    assign armed_next     = armed_reg | (sync_primed & ss_level);

    assign ch_idx     = {cfg_word_reg[CFG_S1], cfg_word_reg[CFG_S0], cfg_word_reg[CFG_OS]};
    assign sel_sample = select_sample(ch_data, cfg_word_reg[CFG_SD], ch_idx);
    assign rx_shifted = {rx_shift_reg[TX_W-2:0], mosi_level};

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        tx_shift_next  = tx_shift_reg;
        rx_shift_next  = rx_shift_reg;
        cfg_word_next  = cfg_word_reg;
        cfg_valid_next = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ss_fall && armed_reg) begin
                    state_next    = ST_SHIFT;
                    tx_shift_next = {sel_sample, 4'b0000};
                    rx_shift_next = '0;
                    bit_cnt_next  = '0;
                end
            end
            ST_SHIFT: begin
                // SS_n rising wins over a coincident SCLK edge: that bit is dropped
                if (ss_rise) begin
                    state_next = ST_IDLE;
                    if (bit_cnt_reg < CNT_W'(FRAME_BITS)) begin
                        frame_err_next = 1'b1;
                    end
                end else if (sclk_rise) begin
                    rx_shift_next = rx_shifted;
                    bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
                    if (bit_cnt_reg == CNT_W'(FRAME_BITS - 1)) begin
                        state_next     = ST_DONE;
                        cfg_word_next  = rx_shifted[TX_W-1 -: CFG_W];
                        cfg_valid_next = 1'b1;
                    end
                end else if (sclk_fall) begin
                    tx_shift_next = tx_shift_reg << 1;
                end
            end
            ST_DONE: begin
                if (ss_rise) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign miso_next = (state_next == ST_SHIFT) & tx_shift_next[TX_W-1];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            tx_shift_reg  <= '0;
            rx_shift_reg  <= '0;
            cfg_word_reg  <= CFG_RESET;
            cfg_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            miso_reg      <= 1'b0;
            armed_reg     <= 1'b0;
            prime_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            tx_shift_reg  <= tx_shift_next;
            rx_shift_reg  <= rx_shift_next;
            cfg_word_reg  <= cfg_word_next;
            cfg_valid_reg <= cfg_valid_next;
            frame_err_reg <= frame_err_next;
            miso_reg      <= miso_next;
            armed_reg     <= armed_next;
            prime_cnt_reg <= prime_cnt_next;
        end
    end

    assign spi_MISO  = miso_reg;
    assign cfg_word  = cfg_word_reg;
    assign cfg_valid = cfg_valid_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench: acts as the SPI master (SCLK = clk/16) and checks MISO
// words, config updates and pulse counts against hand-computed values.
module tb_spi_adc_responder;

    localparam logic [95:0] CH_DEFAULT = {12'h777, 12'h0F0, 12'hDEF, 12'h5A5,
                                          12'h321, 12'h123, 12'h456, 12'hABC};

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic        spi_SCLK;
    logic        spi_SS_n;
    logic        spi_MOSI;
    logic        spi_MISO;
    logic [95:0] ch_data;
    logic [5:0]  cfg_word;
    logic        cfg_valid;
    logic        frame_err;

    int checks       = 0;
    int failures     = 0;
    int valid_pulses = 0;
    int err_pulses   = 0;
    int v0;
    int e0;

    logic [31:0] miso;
    logic [31:0] miso_a;
    logic [31:0] miso_b;
    logic [5:0]  c16;

    always #5 clk_clk = ~clk_clk;

    spi_adc_responder #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .spi_SCLK    (spi_SCLK),
        .spi_SS_n    (spi_SS_n),
        .spi_MOSI    (spi_MOSI),
        .spi_MISO    (spi_MISO),
        .ch_data     (ch_data),
        .cfg_word    (cfg_word),
        .cfg_valid   (cfg_valid),
        .frame_err   (frame_err)
    );

    always @(negedge clk_clk) begin
        if (cfg_valid === 1'b1) valid_pulses++;
        if (frame_err === 1'b1) err_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic ss_drop();
        spi_SS_n = 1'b0;
        wait_clks(8);
    endtask

    task automatic ss_raise();
        spi_SS_n = 1'b1;
        wait_clks(8);
    endtask

    // MISO is sampled at the end of each low half, where a master would latch it
    task automatic clock_bits(input int n, input logic [31:0] mosi_word,
                              output logic [31:0] miso_word, output logic [5:0] cfg_after16);
        miso_word   = '0;
        cfg_after16 = '0;
        for (int i = 0; i < n; i++) begin
            spi_MOSI = mosi_word[n-1-i];
            wait_clks(8);
            miso_word = {miso_word[30:0], spi_MISO};
            spi_SCLK  = 1'b1;
            wait_clks(8);
            if (i == 15) cfg_after16 = cfg_word;
            spi_SCLK = 1'b0;
        end
        wait_clks(4);
    endtask

    task automatic run_frame(input int n, input logic [31:0] mosi_word,
                             output logic [31:0] miso_word, output logic [5:0] cfg_after16);
        ss_drop();
        clock_bits(n, mosi_word, miso_word, cfg_after16);
        ss_raise();
    endtask

    task automatic snap();
        v0 = valid_pulses;
        e0 = err_pulses;
    endtask

    task automatic check_frame(input string tag, input logic [31:0] exp_miso,
                               input logic [5:0] exp_cfg, input int exp_valid, input int exp_err);
        $display("frame %s: miso=0x%0h cfg=%b valid=%0d err=%0d",
                 tag, miso, cfg_word, valid_pulses - v0, err_pulses - e0);
        check_eq({tag, "_miso"},  miso, exp_miso);
        check_eq({tag, "_cfg"},   {26'd0, cfg_word}, {26'd0, exp_cfg});
        check_eq({tag, "_valid"}, valid_pulses - v0, exp_valid);
        check_eq({tag, "_err"},   err_pulses - e0, exp_err);
    endtask

    initial begin
        ch_data     = CH_DEFAULT;
        reset_reset = 1'b1;
        spi_SS_n    = 1'b1;
        spi_SCLK    = 1'b0;
        spi_MOSI    = 1'b0;
        wait_clks(4);
        check_eq("rst_miso",  {31'd0, spi_MISO},  0);
        check_eq("rst_cfg",   {26'd0, cfg_word},  32'h20);
        check_eq("rst_valid", {31'd0, cfg_valid}, 0);
        check_eq("rst_err",   {31'd0, frame_err}, 0);
        reset_reset = 1'b0;
        wait_clks(10);

        // Reset config selects ch0; MOSI 8800 -> cfg 100010 (still ch0)
        snap();
        run_frame(16, 32'h8800, miso, c16);
        check_frame("f1", 32'hABC0, 6'b100010, 1, 0);

        // Configure ch2 (cfg 100100); result still comes from ch0
        snap();
        run_frame(16, 32'h9000, miso, c16);
        check_frame("f2", 32'hABC0, 6'b100100, 1, 0);

        // ch2 = 123 now returned; config rewritten to the same value
        snap();
        run_frame(16, 32'h9000, miso, c16);
        check_frame("f3", 32'h1230, 6'b100100, 1, 0);

        // Abort after 7 SCLKs: first 7 bits of 1230 are 0001001
        snap();
        ss_drop();
        clock_bits(7, 32'h70, miso, c16);
        ss_raise();
        check_frame("abort", 32'h09, 6'b100100, 0, 1);

        // Full frame after abort: ch2 still selected; configure ch5 (111000)
        snap();
        run_frame(16, 32'hE000, miso, c16);
        check_frame("f5", 32'h1230, 6'b111000, 1, 0);

        // 20 SCLKs: ch5 = DEF, then zeros; cfg 111100 latched at the 16th edge
        snap();
        run_frame(20, 32'hF000F, miso, c16);
        check_eq("long_cfg16", {26'd0, c16}, 32'h3C);
        check_frame("long", 32'hDEF00, 6'b111100, 1, 0);

        // Reset at bit 5 with SS_n held low: frame dropped, no response until re-armed
        snap();
        ss_drop();
        clock_bits(5, 32'h12, miso, c16);
        reset_reset = 1'b1;
        wait_clks(3);
        check_eq("midrst_cfg", {26'd0, cfg_word}, 32'h20);
        reset_reset = 1'b0;
        wait_clks(10);
        clock_bits(16, 32'h9000, miso, c16);
        check_frame("held", 32'h0, 6'b100000, 0, 0);
        ss_raise();

        snap();
        run_frame(16, 32'h8800, miso, c16);
        check_frame("rearm", 32'hABC0, 6'b100010, 1, 0);

        // Load S/D=0 config
        snap();
        run_frame(16, 32'h0000, miso, c16);
        check_frame("sd0_cfg", 32'hABC0, 6'b000000, 1, 0);

        // S/D=0 returns zeros even with ch_data toggled mid-frame
        snap();
        ss_drop();
        clock_bits(6, 32'h20, miso_a, c16);
        ch_data = ~CH_DEFAULT;
        clock_bits(10, 32'h0, miso_b, c16);
        ss_raise();
        miso = (miso_a << 10) | miso_b;
        check_frame("sd0_toggle", 32'h0, 6'b100000, 1, 0);
        ch_data = CH_DEFAULT;
        wait_clks(2);

        // ch0 captured at SS_n fall; mid-frame change must not leak into MISO
        snap();
        ss_drop();
        clock_bits(8, 32'h88, miso_a, c16);
        ch_data = ~CH_DEFAULT;
        clock_bits(8, 32'h00, miso_b, c16);
        ss_raise();
        ch_data = CH_DEFAULT;
        miso = (miso_a << 8) | miso_b;
        check_frame("toggle", 32'hABC0, 6'b100010, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
